// File: rtl/guess_autoplayer.sv
// Machine player for the LED guessing game: watches the one-hot LED
// pattern and issues the matching raw button press after a reaction delay.
// Ports: clk, rst_n (async, active-low), en, y[3:0], win, lose,
//        react_dly[DLY_W-1:0], btn[3:0], busy, press_count[7:0].
// Optional macro AUTOPLAY_MISS_EN adds miss_every[3:0] for deliberate
// wrong presses (target rotated left by one).
module guess_autoplayer #(
    parameter int HOLD_CYC = 2**22,
    parameter int DLY_W    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       y,
    input  logic             win,
    input  logic             lose,
    input  logic [DLY_W-1:0] react_dly,
`ifdef AUTOPLAY_MISS_EN
    input  logic [3:0]       miss_every,
`endif
    output logic [3:0]       btn,
    output logic             busy,
    output logic [7:0]       press_count
);

    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PRESS,
        S_RELEASE,
        S_COOLDOWN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       target_q, target_d;
    logic [DLY_W-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic [3:0]       btn_q, btn_d;
    logic [7:0]       press_count_q, press_count_d;

    logic             y_onehot;
    logic [3:0]       press_btn;

    assign y_onehot = (y != 4'd0) && ((y & (y - 4'd1)) == 4'd0);

`ifdef AUTOPLAY_MISS_EN
    // Numerator is one wider so the 256th press still divides correctly.
    logic [8:0] next_num;
    logic       miss;
    assign next_num  = {1'b0, press_count_q} + 9'd1;
    assign miss      = (miss_every != 4'd0) &&
                       ((next_num % {5'd0, miss_every}) == 9'd0);
    assign press_btn = miss ? {target_q[2:0], target_q[3]} : target_q;
`else
    assign press_btn = target_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            target_q      <= 4'd0;
            dcnt_q        <= '0;
            hcnt_q        <= '0;
            btn_q         <= 4'd0;
            press_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            dcnt_q        <= dcnt_d;
            hcnt_q        <= hcnt_d;
            btn_q         <= btn_d;
            press_count_q <= press_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        dcnt_d        = dcnt_q;
        hcnt_d        = hcnt_q;
        btn_d         = btn_q;
        press_count_d = press_count_q;

        if (win || lose) begin
            // Game over beats everything, even a press in progress.
            state_d = S_DONE;
            btn_d   = 4'd0;
            hcnt_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    btn_d = 4'd0;
                    if (en && y_onehot) begin
                        target_d = y;
                        dcnt_d   = react_dly;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if ((y != target_q) || !en) begin
                        state_d = S_IDLE;
                    end else if (dcnt_q == '0) begin
                        state_d = S_PRESS;
                        btn_d   = press_btn;
                        hcnt_d  = '0;
                        if (press_count_q != 8'hFF) begin
                            press_count_d = press_count_q + 8'd1;
                        end
                    end else begin
                        dcnt_d = dcnt_q - 1'b1;
                    end
                end
                S_PRESS: begin
                    if (hcnt_q == HOLD_LAST) begin
                        state_d = S_RELEASE;
                        btn_d   = 4'd0;
                        hcnt_d  = '0;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    btn_d = 4'd0;
                    if (hcnt_q == HOLD_LAST) begin
                        state_d = S_COOLDOWN;
                        hcnt_d  = '0;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
                S_COOLDOWN: begin
                    // Same LED phase must never be pressed twice.
                    btn_d = 4'd0;
                    if (y != target_q) begin
                        state_d = S_IDLE;
                    end
                end
                S_DONE: begin
                    btn_d   = 4'd0;
                    state_d = S_IDLE;
                end
                default: begin
                    btn_d   = 4'd0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign btn         = btn_q;
    assign press_count = press_count_q;
    assign busy        = (state_q == S_WAIT) || (state_q == S_PRESS) ||
                         (state_q == S_RELEASE) || (state_q == S_COOLDOWN);

endmodule

// File: tb/tb_guess_autoplayer.sv
// Self-checking bench for guess_autoplayer (HOLD_CYC=4, DLY_W=8).
// Expected presses are queued on stimulus and popped on each btn rise.
module tb_guess_autoplayer;

    localparam int HOLD = 4;
    localparam int DW   = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [3:0]    y;
    logic          win;
    logic          lose;
    logic [DW-1:0] react_dly;
`ifdef AUTOPLAY_MISS_EN
    logic [3:0]    miss_every;
`endif
    logic [3:0]    btn;
    logic          busy;
    logic [7:0]    press_count;

    int vectors = 0;
    int errors  = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    guess_autoplayer #(.HOLD_CYC(HOLD), .DLY_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .y          (y),
        .win        (win),
        .lose       (lose),
        .react_dly  (react_dly),
`ifdef AUTOPLAY_MISS_EN
        .miss_every (miss_every),
`endif
        .btn        (btn),
        .busy       (busy),
        .press_count(press_count)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0; y = 4'd0; win = 1'b0; lose = 1'b0; react_dly = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Samples on negedges until btn is non-zero; cyc = posedges seen.
    task automatic wait_press(input int bound, output logic [3:0] got,
                              output int cyc);
        got = 4'd0;
        cyc = 0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (btn !== 4'd0) begin
                got = btn;
                break;
            end
        end
    endtask

    task automatic count_high(input int bound, output int n);
        n = 1;
        while (n < bound) begin
            @(negedge clk);
            if (btn === 4'd0) break;
            n++;
        end
    endtask

    task automatic count_low(input int bound, output int n);
        n = 0;
        while (n < bound) begin
            @(negedge clk);
            if (btn !== 4'd0) break;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1; y = 4'b0010; win = 1'b0; lose = 1'b0; react_dly = '0;
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if (btn !== 4'd0 || busy !== 1'b0 || press_count !== 8'd0) begin
                errors++;
                $display("FAIL reset: btn=%b busy=%b cnt=%0d want 0/0/0",
                         btn, busy, press_count);
            end
        end
        rst_n = 1'b1;
        y = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_single_press();
        logic [3:0] got, exp;
        int cyc, n;
        logic bad;
        do_reset();
        en = 1'b1; react_dly = 8'd3; y = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_press(30, got, cyc);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL single_btn: got %b want %b", got, exp);
        end
        vectors++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL single_latency: got %0d want 5", cyc);
        end
        count_high(20, n);
        vectors++;
        if (n != HOLD) begin
            errors++;
            $display("FAIL single_hold: got %0d want %0d", n, HOLD);
        end
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (btn !== 4'd0 || busy !== 1'b1) bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0 || press_count !== 8'd1) begin
            errors++;
            $display("FAIL single_cooldown: bad=%b cnt=%0d want 0/1",
                     bad, press_count);
        end
        y = 4'd0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_exit: busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got, exp;
        int cyc, n;
        do_reset();
        en = 1'b1; react_dly = 8'd0; y = 4'b0001;
        exp_q.push_back(4'b0001);
        wait_press(20, got, cyc);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp || cyc != 2) begin
            errors++;
            $display("FAIL b2b_first: got %b/%0d want %b/2", got, cyc, exp);
        end
        count_high(20, n);
        y = 4'b0010;
        exp_q.push_back(4'b0010);
        count_low(40, n);
        got = btn;
        exp = exp_q.pop_front();
        vectors++;
        if (n != HOLD + 2 || got !== exp) begin
            errors++;
            $display("FAIL b2b_gap: got %0d/%b want %0d/%b",
                     n, got, HOLD + 2, exp);
        end
        vectors++;
        if (press_count !== 8'd2) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 2", press_count);
        end
    endtask

    task automatic test_abort();
        logic [3:0] got, exp;
        int cyc;
        do_reset();
        en = 1'b1; react_dly = 8'd10; y = 4'b0100;
        exp_q.push_back(4'b1000);
        repeat (5) @(negedge clk);
        y = 4'b1000;
        wait_press(40, got, cyc);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp || cyc != 13) begin
            errors++;
            $display("FAIL abort_rearm: got %b/%0d want %b/13", got, cyc, exp);
        end
        vectors++;
        if (press_count !== 8'd1) begin
            errors++;
            $display("FAIL abort_count: got %0d want 1", press_count);
        end
    endtask

    task automatic test_win();
        logic [3:0] got, exp;
        int cyc;
        logic bad;
        do_reset();
        en = 1'b1; react_dly = 8'd0; y = 4'b0001;
        exp_q.push_back(4'b0001);
        wait_press(20, got, cyc);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL win_press: got %b want %b", got, exp);
        end
        @(negedge clk);
        win = 1'b1;
        @(negedge clk);
        vectors++;
        if (btn !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL win_cut: btn=%b busy=%b want 0/0", btn, busy);
        end
        y = 4'b0010;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (btn !== 4'd0 || busy !== 1'b0) bad = 1'b1;
        end
        win = 1'b0; lose = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (btn !== 4'd0 || busy !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL win_done_hold: bad=%b want 0", bad);
        end
        lose = 1'b0;
        exp_q.push_back(4'b0010);
        wait_press(20, got, cyc);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp || press_count !== 8'd2) begin
            errors++;
            $display("FAIL win_resume: got %b/%0d want %b/2",
                     got, press_count, exp);
        end
    endtask

    task automatic test_invalid_and_saturate();
        logic [3:0] got, exp, tgt;
        int cyc, n;
        logic bad;
        do_reset();
        en = 1'b1; react_dly = 8'd0;
        bad = 1'b0;
        y = 4'b0110;
        repeat (10) begin
            @(negedge clk);
            if (btn !== 4'd0 || busy !== 1'b0) bad = 1'b1;
        end
        y = 4'b0000;
        repeat (10) begin
            @(negedge clk);
            if (btn !== 4'd0 || busy !== 1'b0) bad = 1'b1;
        end
        en = 1'b0; y = 4'b1000;
        repeat (10) begin
            @(negedge clk);
            if (btn !== 4'd0 || busy !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL invalid_y: bad=%b want 0", bad);
        end
        en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tgt = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            y = tgt;
            exp_q.push_back(tgt);
            wait_press(30, got, cyc);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL sat_press%0d: got %b want %b", i, got, exp);
            end
            if (i == 254) begin
                vectors++;
                if (press_count !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_255: got %0d want 255", press_count);
                end
            end
            count_high(20, n);
        end
        vectors++;
        if (press_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold: got %0d want 255", press_count);
        end
    endtask

`ifdef AUTOPLAY_MISS_EN
    task automatic test_miss();
        logic [3:0] got, exp;
        logic [3:0] seq_y[3];
        logic [3:0] seq_b[3];
        int cyc, n;
        seq_y = '{4'b0001, 4'b0010, 4'b0100};
        seq_b = '{4'b0001, 4'b0010, 4'b1000};
        do_reset();
        en = 1'b1; react_dly = 8'd0; miss_every = 4'd3;
        for (int i = 0; i < 3; i++) begin
            y = seq_y[i];
            exp_q.push_back(seq_b[i]);
            wait_press(30, got, cyc);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL miss_press%0d: got %b want %b", i, got, exp);
            end
            count_high(20, n);
        end
        miss_every = 4'd0;
    endtask
`endif

    task automatic test_async_reset();
        logic [3:0] got, exp;
        int cyc;
        do_reset();
        en = 1'b1; react_dly = 8'd0; y = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_press(20, got, cyc);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL arst_press: got %b want %b", got, exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (btn !== 4'd0 || busy !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL arst_mid: btn=%b busy=%b cnt=%0d want 0/0/0",
                     btn, busy, press_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        y = 4'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0; y = 4'd0; win = 1'b0; lose = 1'b0; react_dly = '0;
`ifdef AUTOPLAY_MISS_EN
        miss_every = 4'd0;
`endif
        test_reset();
        test_single_press();
        test_back_to_back();
        test_abort();
        test_win();
        test_invalid_and_saturate();
`ifdef AUTOPLAY_MISS_EN
        test_miss();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
